// File: rtl/pll_lock_reset_sequencer.sv
// Sequences the SDRAM and core resets from the PLL lock in the clk50 domain.
// Lock is synchronised, held stable for STABLE_CYCLES, then SDRAM init is awaited before core release.
module pll_lock_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 4096,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CNT_W          = $clog2((STABLE_CYCLES > TIMEOUT_CYCLES) ?
                                          STABLE_CYCLES : TIMEOUT_CYCLES) + 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       locked,
    input  logic       sdram_init_done,
    output logic       sdram_reset_out,
    output logic       core_reset_out,
    output logic [2:0] seq_state,
    output logic [7:0] lock_loss_count,
    output logic       timeout_error
);

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        STABILIZE  = 3'd1,
        SDRAM_INIT = 3'd2,
        RUN        = 3'd3,
        FAULT      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sdram_rst_q, sdram_rst_d;
    logic                   core_rst_q, core_rst_d;
    logic [7:0]             loss_cnt_q, loss_cnt_d;
    logic                   timeout_q, timeout_d;
    logic                   lock_s;

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], locked};
        state_d     = state_q;
        cnt_d       = cnt_q;
        sdram_rst_d = sdram_rst_q;
        core_rst_d  = core_rst_q;
        loss_cnt_d  = loss_cnt_q;
        timeout_d   = timeout_q;

        // Lock loss outranks every other transition outside WAIT_LOCK.
        if (!lock_s && state_q != WAIT_LOCK) begin
            state_d     = WAIT_LOCK;
            cnt_d       = '0;
            sdram_rst_d = 1'b1;
            core_rst_d  = 1'b1;
            if ((state_q == SDRAM_INIT || state_q == RUN) && loss_cnt_q != 8'hFF)
                loss_cnt_d = loss_cnt_q + 8'd1;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    cnt_d       = '0;
                    sdram_rst_d = 1'b1;
                    core_rst_d  = 1'b1;
                    if (lock_s)
                        state_d = STABILIZE;
                end
                STABILIZE: begin
                    if (cnt_q == STABLE_LAST) begin
                        state_d     = SDRAM_INIT;
                        cnt_d       = '0;
                        sdram_rst_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SDRAM_INIT: begin
                    // A done arriving on the timeout cycle still counts as success.
                    if (sdram_init_done) begin
                        state_d    = RUN;
                        cnt_d      = '0;
                        core_rst_d = 1'b0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d     = FAULT;
                        cnt_d       = '0;
                        timeout_d   = 1'b1;
                        sdram_rst_d = 1'b1;
                        core_rst_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    sdram_rst_d = 1'b0;
                    core_rst_d  = 1'b0;
                end
                FAULT: begin
                    sdram_rst_d = 1'b1;
                    core_rst_d  = 1'b1;
                end
                default: begin
                    state_d     = WAIT_LOCK;
                    cnt_d       = '0;
                    sdram_rst_d = 1'b1;
                    core_rst_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q      <= '0;
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            sdram_rst_q <= 1'b1;
            core_rst_q  <= 1'b1;
            loss_cnt_q  <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sdram_rst_q <= sdram_rst_d;
            core_rst_q  <= core_rst_d;
            loss_cnt_q  <= loss_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign sdram_reset_out = sdram_rst_q;
    assign core_reset_out  = core_rst_q;
    assign seq_state       = state_q;
    assign lock_loss_count = loss_cnt_q;
    assign timeout_error   = timeout_q;

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Randomised scenario bench for pll_lock_reset_sequencer; expected timing is derived
// arithmetically from lock-rise / done / drop instants rather than from the state machine.
module tb_pll_lock_reset_sequencer;

    localparam int SYNC    = 2;
    localparam int STABLE  = 16;
    localparam int TIMEOUT = 64;
    // Edges from the first edge that samples locked high to sdram_reset_out falling.
    localparam int LAT     = SYNC + 1 + STABLE;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       locked = 1'b0;
    logic       sdram_init_done = 1'b0;
    logic       sdram_reset_out, core_reset_out, timeout_error;
    logic [2:0] seq_state;
    logic [7:0] lock_loss_count;

    int total = 0;
    int bad   = 0;

    pll_lock_reset_sequencer #(
        .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .locked(locked), .sdram_init_done(sdram_init_done),
        .sdram_reset_out(sdram_reset_out), .core_reset_out(core_reset_out),
        .seq_state(seq_state), .lock_loss_count(lock_loss_count), .timeout_error(timeout_error)
    );

    always #5 clock = ~clock;

    // Core may never be released while SDRAM is still held in reset.
    always @(negedge clock) begin
        if (!reset) begin
            total++;
            if (core_reset_out === 1'b0 && sdram_reset_out !== 1'b0) begin
                bad++;
                $display("FAIL invariant: core=%b sdram=%b at %0t", core_reset_out, sdram_reset_out, $time);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1; locked = 1'b0; sdram_init_done = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic bring_to_init();
        locked = 1'b1;
        step(LAT);
    endtask

    task automatic bring_to_run(input int d);
        bring_to_init();
        step(d);
        sdram_init_done = 1'b1;
        step();
        sdram_init_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({sdram_reset_out, core_reset_out, seq_state, lock_loss_count, timeout_error}
            !== {1'b1, 1'b1, 3'd0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values: got sdr=%b core=%b st=%0d llc=%0d to=%b want 1 1 0 0 0",
                     sdram_reset_out, core_reset_out, seq_state, lock_loss_count, timeout_error);
        end
    endtask

    task automatic test_bringup();
        int d;
        logic [2:0] exp_st;
        do_reset();
        locked = 1'b1;
        for (int n = 1; n <= LAT; n++) begin
            step();
            exp_st = (n < SYNC + 1) ? 3'd0 : (n < LAT) ? 3'd1 : 3'd2;
            total++;
            if (sdram_reset_out !== (n < LAT) || seq_state !== exp_st) begin
                bad++;
                $display("FAIL bringup edge %0d: sdr=%b st=%0d want sdr=%b st=%0d",
                         n, sdram_reset_out, seq_state, (n < LAT), exp_st);
            end
        end
        d = $urandom_range(1, 40);
        step(d);
        total++;
        if (core_reset_out !== 1'b1 || seq_state !== 3'd2) begin
            bad++;
            $display("FAIL bringup pre_done: core=%b st=%0d want 1 2", core_reset_out, seq_state);
        end
        sdram_init_done = 1'b1;
        step();
        sdram_init_done = 1'b0;
        total++;
        if (core_reset_out !== 1'b0 || seq_state !== 3'd3 || timeout_error !== 1'b0) begin
            bad++;
            $display("FAIL bringup core_release: core=%b st=%0d to=%b want 0 3 0",
                     core_reset_out, seq_state, timeout_error);
        end
    endtask

    task automatic test_glitch();
        int g;
        logic [2:0] exp_st;
        do_reset();
        g = $urandom_range(SYNC + 1, LAT - SYNC - 1);
        locked = 1'b1;
        for (int n = 1; n <= g + 1 + LAT; n++) begin
            if (n == g + 1) locked = 1'b0;
            if (n == g + 2) locked = 1'b1;
            step();
            // Low sampled at edge g+1 reaches the FSM at g+3; the re-rise restarts the full count.
            if (n < SYNC + 1)                exp_st = 3'd0;
            else if (n < g + SYNC + 1)       exp_st = 3'd1;
            else if (n == g + SYNC + 1)      exp_st = 3'd0;
            else if (n < g + 1 + LAT)        exp_st = 3'd1;
            else                             exp_st = 3'd2;
            total++;
            if (sdram_reset_out !== (n < g + 1 + LAT) || seq_state !== exp_st) begin
                bad++;
                $display("FAIL glitch g=%0d edge %0d: sdr=%b st=%0d want sdr=%b st=%0d",
                         g, n, sdram_reset_out, seq_state, (n < g + 1 + LAT), exp_st);
            end
        end
        total++;
        if (lock_loss_count !== 8'd0) begin
            bad++;
            $display("FAIL glitch lock_loss_count: got %0d want 0", lock_loss_count);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        bring_to_init();
        for (int j = 1; j <= TIMEOUT; j++) begin
            step();
            total++;
            if (seq_state !== ((j < TIMEOUT) ? 3'd2 : 3'd4) || timeout_error !== (j == TIMEOUT)) begin
                bad++;
                $display("FAIL timeout edge %0d: st=%0d to=%b", j, seq_state, timeout_error);
            end
        end
        total++;
        if (sdram_reset_out !== 1'b1 || core_reset_out !== 1'b1) begin
            bad++;
            $display("FAIL timeout resets: sdr=%b core=%b want 1 1", sdram_reset_out, core_reset_out);
        end
        locked = 1'b0;
        step(SYNC + 1);
        total++;
        if (seq_state !== 3'd0 || lock_loss_count !== 8'd0 || timeout_error !== 1'b1) begin
            bad++;
            $display("FAIL fault_exit: st=%0d llc=%0d to=%b want 0 0 1", seq_state, lock_loss_count, timeout_error);
        end
        bring_to_run($urandom_range(1, 30));
        total++;
        if (seq_state !== 3'd3 || sdram_reset_out !== 1'b0 || core_reset_out !== 1'b0 || timeout_error !== 1'b1) begin
            bad++;
            $display("FAIL rerun: st=%0d sdr=%b core=%b to=%b want 3 0 0 1",
                     seq_state, sdram_reset_out, core_reset_out, timeout_error);
        end
    endtask

    task automatic test_lock_loss();
        int m;
        logic exp_core;
        do_reset();
        m = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                bring_to_run($urandom_range(1, 10));
                step($urandom_range(0, 5));
                exp_core = 1'b0;
            end else begin
                bring_to_init();
                step($urandom_range(0, 20));
                exp_core = 1'b1;
            end
            locked = 1'b0;
            step(SYNC);
            total++;
            if (sdram_reset_out !== 1'b0 || core_reset_out !== exp_core) begin
                bad++;
                $display("FAIL loss_pre iter %0d: sdr=%b core=%b want 0 %b", i, sdram_reset_out, core_reset_out, exp_core);
            end
            step();
            m = (m < 255) ? m + 1 : 255;
            total++;
            if (sdram_reset_out !== 1'b1 || core_reset_out !== 1'b1 || lock_loss_count !== 8'(m)) begin
                bad++;
                $display("FAIL loss iter %0d: sdr=%b core=%b llc=%0d want 1 1 %0d",
                         i, sdram_reset_out, core_reset_out, lock_loss_count, m);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bring_to_init();
        step(TIMEOUT);
        locked = 1'b0;
        step(SYNC + 1);
        bring_to_init();
        step(2);
        locked = 1'b0;
        step(SYNC + 1);
        bring_to_init();
        step(3);
        total++;
        if (seq_state !== 3'd2 || timeout_error !== 1'b1 || lock_loss_count !== 8'd1) begin
            bad++;
            $display("FAIL reset_mid setup: st=%0d to=%b llc=%0d want 2 1 1", seq_state, timeout_error, lock_loss_count);
        end
        reset = 1'b1;
        step();
        total++;
        if ({sdram_reset_out, core_reset_out, seq_state, lock_loss_count, timeout_error}
            !== {1'b1, 1'b1, 3'd0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid values: sdr=%b core=%b st=%0d llc=%0d to=%b want 1 1 0 0 0",
                     sdram_reset_out, core_reset_out, seq_state, lock_loss_count, timeout_error);
        end
        reset = 1'b0;
        step(LAT - 1);
        total++;
        if (sdram_reset_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid restart_early: sdr=%b want 1", sdram_reset_out);
        end
        step();
        total++;
        if (sdram_reset_out !== 1'b0 || seq_state !== 3'd2) begin
            bad++;
            $display("FAIL reset_mid restart: sdr=%b st=%0d want 0 2", sdram_reset_out, seq_state);
        end
    endtask

    task automatic test_done_on_timeout();
        do_reset();
        bring_to_init();
        step(TIMEOUT - 1);
        sdram_init_done = 1'b1;
        step();
        sdram_init_done = 1'b0;
        total++;
        if (seq_state !== 3'd3 || core_reset_out !== 1'b0 || timeout_error !== 1'b0) begin
            bad++;
            $display("FAIL done_on_timeout: st=%0d core=%b to=%b want 3 0 0", seq_state, core_reset_out, timeout_error);
        end
        step(5);
        total++;
        if (seq_state !== 3'd3 || timeout_error !== 1'b0) begin
            bad++;
            $display("FAIL done_on_timeout hold: st=%0d to=%b want 3 0", seq_state, timeout_error);
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_glitch();
        test_timeout();
        test_lock_loss();
        test_reset_mid();
        test_done_on_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
